regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per register entry.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning address width; depth is 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of independent read ports (1..8).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have port clear, input, 1, synchronous clear of all entries and valid bits.
REQ-007 SHALL have port wr_en, input, 1, write strobe.
REQ-008 SHALL have port wr_addr, input, ADDR_W, write address.
REQ-009 SHALL have port wr_data, input, DATA_W, write data.
REQ-010 SHALL have port rd_en, input, NUM_RD, per-port read strobe; bit k belongs to port k.
REQ-011 SHALL have port rd_addr, input, NUM_RD*ADDR_W, packed addresses; port k occupies slice [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rd_data, output, NUM_RD*DATA_W, packed registered read data.
REQ-013 SHALL have port rd_valid, output, NUM_RD, per-port flag: entry returned had been written since the last reset or clear.

Function
REQ-014 SHALL hold a per-entry valid bit; a write sets it and a clear resets every bit.
REQ-015 SHALL give a read latency of exactly 1 cycle: rd_en[k] high at edge N updates rd_data/rd_valid slice k after edge N.
REQ-016 SHALL hold a port's rd_data and rd_valid slices unchanged while its rd_en bit is low.
REQ-017 SHALL let all NUM_RD ports read any address, including the same address, in the same cycle without conflict.
REQ-018 SHALL, on a read and write to the same address in one cycle, return per REQ-024/REQ-025 and never suppress the read.
REQ-019 SHALL, when clear and wr_en are both high, apply clear only; the write is dropped.
REQ-020 SHALL, when clear is high, return zero data and rd_valid=0 on ports reading that cycle.
REQ-021 SHALL treat every address in 0..2**ADDR_W-1 as valid; no entry is hardwired.

Reset
REQ-022 SHALL, while reset is high, immediately force all entries, valid bits, rd_data and rd_valid to 0, independent of clk.
REQ-023 SHALL ignore every input while reset is high; operation resumes on the first rising edge after reset is deasserted.

Configuration
REQ-024 SHALL, with REGFILE_BYPASS_EN defined, forward wr_data and rd_valid=1 to a port reading wr_addr while wr_en is high in the same cycle.
REQ-025 SHALL, without REGFILE_BYPASS_EN, return the entry's pre-write contents and pre-write valid bit in that case.

Structure
REQ-026 SHALL take default DATA_W/ADDR_W/NUM_RD constants from shared package regfile_pkg.
REQ-027 SHALL implement one read port (mux, bypass compare, output register) as sub-module regfile_rd_port, generated NUM_RD times.

Verification (defaults unless stated)
REQ-028 SHALL cover this case: reset high mid-run with entries written -> rd_data=0, rd_valid=0 immediately; a read of addr 5 after release -> 0x00, valid 0.
REQ-029 SHALL cover this case: write 0xA5 to addr 2, then next cycle read port0=2 and port1=2 -> both 0xA5, valid 1, one cycle later.
REQ-030 SHALL cover this case: same-cycle write 0x3C to addr 4 and read port0=4, where addr 4 held 0x11 -> 0x3C with bypass enabled, 0x11 without.
REQ-031 SHALL cover this case: clear and a write of 0x77 to addr 1 in the same cycle, then a read of addr 1 -> 0x00, valid 0.
REQ-032 SHALL cover this case: rd_en low for 3 cycles after a read returned 0x5A while addr is rewritten -> output stays 0x5A.
REQ-033 SHALL cover this case: NUM_RD=4, DATA_W=16, ADDR_W=4, write 0xBEEF to addr 15 and read it on all 4 ports -> all 0xBEEF.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared default sizes and the build-time bypass switch (macro REGFILE_BYPASS_EN)
package regfile_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_NUM_RD = 2;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif
endpackage

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one registered read port (entry mux, write-bypass compare, output register)
//   in : clk, reset (async, active-high), clear, wr_en/wr_addr/wr_data, mem/valid (whole array), rd_en, rd_addr
//   out: rd_data, rd_valid (updated one cycle after rd_en, held while rd_en is low)
//   REGFILE_BYPASS_EN selects forwarding of same-cycle write data via regfile_pkg::BYPASS_EN
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 clear,
  input  logic                                 wr_en,
  input  logic [ADDR_W-1:0]                    wr_addr,
  input  logic [DATA_W-1:0]                    wr_data,
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]   mem,
  input  logic [(1<<ADDR_W)-1:0]               valid,
  input  logic                                 rd_en,
  input  logic [ADDR_W-1:0]                    rd_addr,
  output logic [DATA_W-1:0]                    rd_data,
  output logic                                 rd_valid
);
  logic              w_byp;
  logic [DATA_W-1:0] w_data;
  logic              w_valid;
  always_comb begin
    w_byp   = BYPASS_EN && wr_en && (wr_addr == rd_addr);
    w_data  = clear ? '0 : w_byp ? wr_data : mem[rd_addr];
    w_valid = !clear && (w_byp || valid[rd_addr]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_data  <= w_data;
      rd_valid <= w_valid;
    end
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parameterised register file, one write port, NUM_RD registered read ports
//   in : clk, reset (async, active-high), clear (sync), wr_en/wr_addr/wr_data, rd_en[NUM_RD], rd_addr[NUM_RD*ADDR_W]
//   out: rd_data[NUM_RD*DATA_W], rd_valid[NUM_RD]
//   build option: define REGFILE_BYPASS_EN to forward same-cycle write data to matching reads
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0]             r_valid;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_mem   <= '0;
      r_valid <= '0;
    end else if (clear) begin
      r_mem   <= '0;
      r_valid <= '0;
    end else if (wr_en) begin
      r_mem[wr_addr]   <= wr_data;
      r_valid[wr_addr] <= 1'b1;
    end
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .mem     (r_mem),
      .valid   (r_valid),
      .rd_en   (rd_en[k]),
      .rd_addr (rd_addr[k*ADDR_W +: ADDR_W]),
      .rd_data (rd_data[k*DATA_W +: DATA_W]),
      .rd_valid(rd_valid[k])
    );
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed plus random checks of regfile_param against an array-based reference model
module tb_regfile_param;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [1:0] rd_en = '0;
  logic [5:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic [1:0]  rd_valid;
  logic        b_wr_en = 1'b0;
  logic [3:0]  b_wr_addr = '0;
  logic [15:0] b_wr_data = '0;
  logic [3:0]  b_rd_en = '0;
  logic [15:0] b_rd_addr = '0;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_valid;
  int checks = 0;
  int failures = 0;
  logic [7:0] m_mem [8];
  bit         m_val [8];
  logic [7:0] exp_d [2];
  bit         exp_v [2];

  always #5 clk = ~clk;

  regfile_param u_dut (
    .clk(clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4)) u_dut4 (
    .clk(clk), .reset(reset), .clear(1'b0), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      exp_d[k] = '0;
      exp_v[k] = 1'b0;
    end
  endtask

  task automatic check(input string tag);
    for (int k = 0; k < 2; k++) begin
      checks++;
      assert (rd_data[k*8 +: 8] === exp_d[k])
        else begin failures++; $error("FAIL %s data port%0d got=%h exp=%h", tag, k, rd_data[k*8 +: 8], exp_d[k]); end
      checks++;
      assert (rd_valid[k] === exp_v[k])
        else begin failures++; $error("FAIL %s valid port%0d got=%b exp=%b", tag, k, rd_valid[k], exp_v[k]); end
    end
  endtask

  task automatic step(input string tag, input logic c, input logic we, input logic [2:0] wa,
                      input logic [7:0] wd, input logic [1:0] re, input logic [5:0] ra);
    logic [2:0] a;
    @(negedge clk);
    clear = c; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (re[k]) begin
        a = ra[k*3 +: 3];
        if (c) begin exp_d[k] = '0; exp_v[k] = 1'b0; end
        else if (BYP && we && wa == a) begin exp_d[k] = wd; exp_v[k] = 1'b1; end
        else begin exp_d[k] = m_mem[a]; exp_v[k] = m_val[a]; end
      end
    end
    if (c) for (int i = 0; i < 8; i++) begin m_mem[i] = '0; m_val[i] = 1'b0; end
    else if (we) begin m_mem[wa] = wd; m_val[wa] = 1'b1; end
    #1 check(tag);
  endtask

  initial begin
    model_reset();
    #1 check("reset_init");
    @(negedge clk);
    reset = 1'b0;
    step("wr_a5", 0, 1, 3'd2, 8'hA5, 2'b00, 6'd0);
    step("rd_dual_same", 0, 0, 3'd0, 8'h00, 2'b11, {3'd2, 3'd2});
    checks++;
    assert (rd_data === 16'hA5A5 && rd_valid === 2'b11)
      else begin failures++; $error("FAIL dual_a5 got=%h/%b exp=a5a5/11", rd_data, rd_valid); end
    step("rd_unwritten", 0, 0, 3'd0, 8'h00, 2'b11, {3'd7, 3'd0});
    step("wr_11", 0, 1, 3'd4, 8'h11, 2'b00, 6'd0);
    step("rw_same", 0, 1, 3'd4, 8'h3C, 2'b01, {3'd0, 3'd4});
    checks++;
    assert (rd_data[7:0] === (BYP ? 8'h3C : 8'h11))
      else begin failures++; $error("FAIL rw_same_const got=%h exp=%h", rd_data[7:0], BYP ? 8'h3C : 8'h11); end
    step("rd_after_rw", 0, 0, 3'd0, 8'h00, 2'b10, {3'd4, 3'd0});
    step("wr_1", 0, 1, 3'd1, 8'h12, 2'b00, 6'd0);
    step("clr_wr", 1, 1, 3'd1, 8'h77, 2'b00, 6'd0);
    step("rd_after_clr", 0, 0, 3'd0, 8'h00, 2'b11, {3'd1, 3'd2});
    step("clr_with_rd", 1, 0, 3'd0, 8'h00, 2'b01, 6'd0);
    step("wr_5a", 0, 1, 3'd6, 8'h5A, 2'b00, 6'd0);
    step("rd_5a", 0, 0, 3'd0, 8'h00, 2'b01, {3'd0, 3'd6});
    step("hold1", 0, 1, 3'd6, 8'h01, 2'b00, {3'd0, 3'd6});
    step("hold2", 0, 1, 3'd6, 8'h02, 2'b00, {3'd0, 3'd6});
    step("hold3", 0, 1, 3'd6, 8'h03, 2'b00, {3'd0, 3'd6});
    checks++;
    assert (rd_data[7:0] === 8'h5A)
      else begin failures++; $error("FAIL hold_5a got=%h exp=5a", rd_data[7:0]); end
    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(15) == 0, 1'($urandom), 3'($urandom), 8'($urandom),
           2'($urandom), 6'($urandom));
    step("wr_pre_rst", 0, 1, 3'd5, 8'h99, 2'b11, {3'd5, 3'd3});
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 8'hEE; rd_en = 2'b11; rd_addr = {3'd5, 3'd5};
    #1 reset = 1'b1;
    model_reset();
    #1 check("rst_async");
    @(posedge clk);
    #1 check("rst_held");
    @(negedge clk);
    reset = 1'b0; wr_en = 1'b0; rd_en = 2'b00;
    step("rd5_after_rst", 0, 0, 3'd0, 8'h00, 2'b01, {3'd0, 3'd5});
    @(negedge clk);
    b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 16'hBEEF;
    @(negedge clk);
    b_wr_en = 1'b0; b_rd_en = 4'hF; b_rd_addr = {4{4'd15}};
    @(negedge clk);
    b_rd_en = 4'h0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      assert (b_rd_data[k*16 +: 16] === 16'hBEEF && b_rd_valid[k] === 1'b1)
        else begin failures++; $error("FAIL wide_port%0d got=%h/%b exp=beef/1", k, b_rd_data[k*16 +: 16], b_rd_valid[k]); end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
